impulse_generator: RTL and testbench
====================================

IMPULSE_GENERATOR -- requirements
Module: impulse_generator

Interface
REQ-001 Parameter CNT_W, default 12: width of the pulse-count request and the sent-pulse count.
REQ-002 Parameter PER_W, default 8: width of the high-phase and low-phase length fields.
REQ-003 The module SHALL have one clock and a synchronous, active-high reset, with ports as follows:
clk  input  1  single clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request a pulse train; sampled only in IDLE
abort  input  1  terminate the train in progress
count  input  CNT_W  number of pulses requested; latched on accepted start
high_len  input  PER_W  impulse high time in clk cycles; latched on accepted start
low_len  input  PER_W  impulse low time in clk cycles; latched on accepted start
impulse  output  1  pulse train, registered, glitch-free; drives a channel counter input
busy  output  1  train in progress
done  output  1  one-cycle strobe on normal completion
sent  output  CNT_W  pulses emitted in the current or last train

Function
REQ-004 FSM states: IDLE, HIGH, LOW, DONE.
REQ-005 IDLE: start=1 and abort=0 -> latch count/high_len/low_len, clear sent, go to HIGH on the next cycle.
REQ-006 Transition timing: start sampled at edge N; impulse=1 and busy=1 from cycle N+1.
REQ-007 HIGH: impulse=1 for max(high_len,1) cycles; sent increments by 1 on entry to HIGH; then go to LOW.
REQ-008 LOW: impulse=0 for max(low_len,1) cycles; afterwards go to HIGH if pulses remain, else go to DONE.
REQ-009 DONE: lasts one cycle, with done=1, busy=0, impulse=0; then IDLE.
REQ-010 busy=1 exactly in HIGH and LOW.
REQ-011 count=0 means 2^CNT_W pulses (4096 by default); sent wraps 4095->0 on the last pulse, matching counter overflow.
REQ-012 Phase length values of 0 SHALL be treated as 1; no state is ever zero cycles long.
REQ-013 start is ignored outside IDLE; latched parameters are unaffected by input changes during a train.
REQ-014 abort=1 in HIGH or LOW -> IDLE on the next edge: impulse=0, done not asserted, sent holds.
REQ-015 abort in IDLE or DONE has no effect, except that abort=1 with start=1 in IDLE suppresses the start.
REQ-016 Every rising edge of impulse is exactly one counted pulse; no runt pulses occur, including on abort.
REQ-017 sent holds its final value in IDLE until the next accepted start.

Reset
REQ-018 reset=1 at a clock edge -> state IDLE, impulse=0, busy=0, done=0, sent=0, latched fields=0.
REQ-019 reset mid-train terminates the train immediately, with no done strobe.
REQ-020 reset has priority over start and abort.

Structure
REQ-021 A shared package SHALL hold the FSM state enum and the CNT_W/PER_W default constants.
REQ-022 One sub-module, phase_timer, SHALL provide a loadable PER_W-bit down-counter with an expiry flag, reused for the HIGH and LOW phases.
REQ-023 The remaining-pulse counter is CNT_W+1 bits wide so that 2^CNT_W pulses are representable.

Verification
REQ-024 Basic train: start at cycle 0 with count=3, high_len=2, low_len=1 -> impulse over cycles 1..9 = 1,1,0,1,1,0,1,1,0; done=1 at cycle 10; sent=3; busy=1 in cycles 1..9.
REQ-025 Zero lengths: count=2, high_len=0, low_len=0 -> impulse = 1,0,1,0; done at cycle 5; sent=2.
REQ-026 Wrap: count=0, high_len=1, low_len=1 -> 4096 pulses, done at cycle 8193, sent=0; an attached 12-bit channel counter reads 0 with ovf=1.
REQ-027 Abort: count=5, high_len=3, low_len=3, abort during the second HIGH -> impulse=0 next cycle, no done, sent=2, busy=0.
REQ-028 Ignored inputs: start plus changed count during a train, and start+abort together in IDLE -> the train is unchanged and no new train begins.
REQ-029 Reset mid-LOW: all outputs 0 on the next cycle, and a subsequent start behaves as in REQ-024.

Source files
------------

// File: rtl/impulse_generator_pkg.sv
// Shared definitions for the impulse generator: FSM state encoding and default widths.
package impulse_generator_pkg;

    localparam int CNT_W_DEFAULT = 12;
    localparam int PER_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/impulse_generator_phase_timer.sv
// Loadable down-counter timing one HIGH or LOW phase; expired flags the phase's last cycle.
module impulse_generator_phase_timer #(
    parameter int PER_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [PER_W-1:0] load_val,
    output logic             expired
);

    logic [PER_W-1:0] cnt_r;

    // Count down to zero and park there until the next load.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {PER_W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != {PER_W{1'b0}}) begin
            cnt_r <= cnt_r - {{(PER_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = (cnt_r == {PER_W{1'b0}});

endmodule

// File: rtl/impulse_generator.sv
// Pulse-train generator: emits count pulses of programmable high/low length with abort.
module impulse_generator
    import impulse_generator_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT,
    parameter int PER_W = PER_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] count,
    input  logic [PER_W-1:0] high_len,
    input  logic [PER_W-1:0] low_len,
    output logic             impulse,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sent
);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W:0]   rem_r;
    logic [CNT_W-1:0] sent_r;
    logic [PER_W-1:0] high_r;
    logic [PER_W-1:0] low_r;
    logic             load_s;
    logic [PER_W-1:0] load_val_s;
    logic             accept_s;
    logic             enter_high_s;
    logic             expired_s;

    // A zero length behaves as one cycle; the timer holds cycles-minus-one.
    function automatic logic [PER_W-1:0] phase_load(input logic [PER_W-1:0] len);
        return (len == {PER_W{1'b0}}) ? {PER_W{1'b0}} : len - {{(PER_W-1){1'b0}}, 1'b1};
    endfunction

    impulse_generator_phase_timer #(.PER_W(PER_W)) phase_timer_i (
        .clk      (clk),
        .reset    (reset),
        .load     (load_s),
        .load_val (load_val_s),
        .expired  (expired_s)
    );

    // Next-state decode and phase-timer reload requests.
    always_comb begin
        state_nxt_s  = state_r;
        load_s       = 1'b0;
        load_val_s   = {PER_W{1'b0}};
        accept_s     = 1'b0;
        enter_high_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start && !abort) begin
                    state_nxt_s = HIGH;
                    accept_s    = 1'b1;
                    load_s      = 1'b1;
                    load_val_s  = phase_load(high_len);
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            HIGH: begin
                if (abort) begin
                    state_nxt_s = IDLE;
                end else if (expired_s) begin
                    state_nxt_s = LOW;
                    load_s      = 1'b1;
                    load_val_s  = phase_load(low_r);
                end else begin
                    state_nxt_s = HIGH;
                end
            end
            LOW: begin
                if (abort) begin
                    state_nxt_s = IDLE;
                end else if (expired_s) begin
                    if (rem_r != {(CNT_W+1){1'b0}}) begin
                        state_nxt_s  = HIGH;
                        enter_high_s = 1'b1;
                        load_s       = 1'b1;
                        load_val_s   = phase_load(high_r);
                    end else begin
                        state_nxt_s = DONE;
                    end
                end else begin
                    state_nxt_s = LOW;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, registered outputs and train bookkeeping; outputs decode the next state so they are flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            impulse <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rem_r   <= {(CNT_W+1){1'b0}};
            sent_r  <= {CNT_W{1'b0}};
            high_r  <= {PER_W{1'b0}};
            low_r   <= {PER_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            impulse <= (state_nxt_s == HIGH);
            busy    <= (state_nxt_s == HIGH) || (state_nxt_s == LOW);
            done    <= (state_nxt_s == DONE);
            if (accept_s) begin
                high_r <= high_len;
                low_r  <= low_len;
                // count of zero requests 2^CNT_W pulses; the first one is emitted now.
                rem_r  <= ((count == {CNT_W{1'b0}}) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, count})
                          - {{CNT_W{1'b0}}, 1'b1};
                sent_r <= {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (enter_high_s) begin
                rem_r  <= rem_r - {{CNT_W{1'b0}}, 1'b1};
                sent_r <= sent_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                rem_r  <= rem_r;
                sent_r <= sent_r;
            end
        end
    end

    assign sent = sent_r;

endmodule

// File: tb/tb_impulse_generator.sv
// Scoreboard bench for impulse_generator: each train end is checked against a per-train summary model.
module tb_impulse_generator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [11:0] count = 12'd0;
    logic [7:0]  high_len = 8'd0;
    logic [7:0]  low_len = 8'd0;
    logic        impulse;
    logic        busy;
    logic        done;
    logic [11:0] sent;

    typedef struct {
        int done_exp;
        int sent_exp;
        int pulses;
        int highs;
        int busyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   n_events = 0;
    int   last_sent = 0;

    impulse_generator dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .count    (count),
        .high_len (high_len),
        .low_len  (low_len),
        .impulse  (impulse),
        .busy     (busy),
        .done     (done),
        .sent     (sent)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Summary of a train: stop_at=0 runs to completion, otherwise the train is cut after busy cycle stop_at.
    function automatic exp_t model(int c, int h, int l, int stop_at, bit by_reset);
        exp_t e;
        int n   = (c == 0) ? 4096 : c;
        int he  = (h == 0) ? 1 : h;
        int le  = (l == 0) ? 1 : l;
        int per = he + le;
        int k   = (stop_at > 0) ? stop_at : n * per;
        e.busyc  = k;
        e.highs  = 0;
        e.pulses = 0;
        for (int t = 0; t < k; t++) begin
            if ((t % per) < he) e.highs++;
            if ((t % per) == 0) e.pulses++;
        end
        e.done_exp = (stop_at == 0) ? 1 : 0;
        e.sent_exp = by_reset ? 0 : (e.pulses % 4096);
        return e;
    endfunction

    // Monitor: accumulate per-train activity, check the summary whenever busy falls.
    initial begin
        int prev_busy = 0;
        int prev_imp  = 0;
        int busy_cnt  = 0;
        int high_cnt  = 0;
        int edges     = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy) begin
                busy_cnt++;
                if (impulse) high_cnt++;
                if (impulse && prev_imp == 0) edges++;
            end
            if (impulse && !busy) chk("impulse_outside_busy", 1, 0);
            if (prev_busy == 1 && !busy) begin
                if (sb.size() == 0) begin
                    chk("unexpected_train_end", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("done", int'(done), e.done_exp);
                    chk("sent", int'(sent), e.sent_exp);
                    chk("pulses", edges, e.pulses);
                    chk("high_cycles", high_cnt, e.highs);
                    chk("busy_cycles", busy_cnt, e.busyc);
                    chk("impulse_at_end", int'(impulse), 0);
                end
                n_events++;
                busy_cnt = 0;
                high_cnt = 0;
                edges    = 0;
            end else if (done) begin
                chk("stray_done", 1, 0);
            end
            prev_busy = int'(busy);
            prev_imp  = int'(impulse);
        end
    end

    task automatic run_train(int c, int h, int l, int stop_at, bit by_reset);
        exp_t e;
        int   ev0;
        int   n;
        int   budget;
        bit   seen;
        e = model(c, h, l, stop_at, by_reset);
        sb.push_back(e);
        ev0      = n_events;
        n        = (c == 0) ? 4096 : c;
        budget   = n * (((h == 0) ? 1 : h) + ((l == 0) ? 1 : l)) + 20;
        start    = 1'b1;
        count    = 12'(c);
        high_len = 8'(h);
        low_len  = 8'(l);
        @(posedge clk); #1;
        start    = (stop_at == 0) ? 1'(($urandom_range(0, 1))) : 1'b0;
        count    = 12'($urandom);
        high_len = 8'($urandom);
        low_len  = 8'($urandom);
        if (stop_at > 0) begin
            for (int t = 1; t < stop_at; t++) begin
                @(posedge clk); #1;
            end
            if (by_reset) reset = 1'b1;
            else abort = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            abort = 1'b0;
        end else begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (n_events > ev0) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!seen) chk("train_end_timeout", 0, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("sent_hold_idle", int'(sent), e.sent_exp);
        last_sent = e.sent_exp;
    endtask

    initial begin
        int c, h, l, per, total, mode;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_impulse", int'(impulse), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_sent", int'(sent), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_train(3, 2, 1, 0, 1'b0);
        run_train(2, 0, 0, 0, 1'b0);
        run_train(5, 3, 3, 8, 1'b0);
        run_train(3, 2, 3, 4, 1'b1);
        chk("reset_clears_sent", int'(sent), 0);
        run_train(3, 2, 1, 0, 1'b0);

        start = 1'b1;
        abort = 1'b1;
        count = 12'd3;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        @(posedge clk); #1;
        chk("start_abort_busy", int'(busy), 0);
        chk("start_abort_sent", int'(sent), last_sent);

        run_train(0, 1, 1, 0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            c     = $urandom_range(1, 6);
            h     = $urandom_range(0, 4);
            l     = $urandom_range(0, 4);
            per   = ((h == 0) ? 1 : h) + ((l == 0) ? 1 : l);
            total = c * per;
            mode  = $urandom_range(0, 3);
            if (mode == 0) run_train(c, h, l, $urandom_range(1, total), 1'b0);
            else if (mode == 1) run_train(c, h, l, $urandom_range(1, total), 1'b1);
            else run_train(c, h, l, 0, 1'b0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
